// File: rtl/knot_stim_driver_if.sv
// Bus between the knot stimulus driver, its host and the controller under test.
// The host side drives the control inputs and returns the controller outputs on y.
interface knot_stim_driver_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             start;
    logic             seed_load;
    logic [6:0]       seed_in;
    logic [CNT_W-1:0] nvec;
    logic [8:0]       y;
    logic [6:0]       x;
    logic             dut_rst;
    logic             busy;
    logic             done;
    logic [15:0]      signature;
    logic [CNT_W-1:0] vec_count;

    modport master (
        output start, seed_load, seed_in, nvec, y,
        input  x, dut_rst, busy, done, signature, vec_count
    );

    modport slave (
        input  start, seed_load, seed_in, nvec, y,
        output x, dut_rst, busy, done, signature, vec_count
    );
endinterface

// File: rtl/knot_stim_driver.sv
// LFSR stimulus driver for the 9-state knot controller.
// Primes the controller with its reset, applies N vectors and compresses y into a 16-bit MISR.
module knot_stim_driver #(
    parameter logic [6:0]  SEED      = 7'h01,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned PRIME_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    knot_stim_driver_if.slave  bus
);
    localparam int unsigned PW = (PRIME_CYC > 1) ? $clog2(PRIME_CYC) : 1;
    localparam logic [PW-1:0] PrimeLast = PW'(PRIME_CYC - 1);

    typedef enum logic [1:0] {StIdle, StPrime, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [6:0]       lfsr_q, lfsr_d;
    logic [15:0]      misr_q, misr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [PW-1:0]    prime_q, prime_d;
    logic [6:0]       x_q, x_d;
    logic             dut_rst_q, dut_rst_d;

    logic [6:0]       lfsr_next;
    logic [15:0]      misr_next;
    logic [CNT_W-1:0] cnt_inc;

    assign lfsr_next = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    assign misr_next = {misr_q[14:0], 1'b0} ^ (misr_q[15] ? 16'h1021 : 16'h0000)
                     ^ {7'b0, bus.y};
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        misr_d    = misr_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        prime_d   = prime_q;
        x_d       = x_q;
        dut_rst_d = dut_rst_q;

        unique case (state_q)
            StIdle, StDone: begin
                // A seed loaded together with start is the one the new run uses.
                if (state_q == StIdle && bus.seed_load) begin
                    lfsr_d = (bus.seed_in == 7'h00) ? SEED : bus.seed_in;
                end
                if (bus.start) begin
                    n_d     = bus.nvec;
                    misr_d  = '0;
                    cnt_d   = '0;
                    prime_d = '0;
                    x_d     = '0;
                    if (bus.nvec != '0) begin
                        state_d   = StPrime;
                        dut_rst_d = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StPrime: begin
                if (prime_q == PrimeLast) begin
                    state_d   = StRun;
                    dut_rst_d = 1'b0;
                    x_d       = lfsr_q;
                    lfsr_d    = lfsr_next;
                end else begin
                    prime_d = prime_q + PW'(1);
                end
            end
            StRun: begin
                // y reflects the vector held during the cycle ending at this edge.
                misr_d = misr_next;
                cnt_d  = cnt_inc;
                if (cnt_inc == n_q) begin
                    state_d = StDone;
                    x_d     = '0;
                end else begin
                    x_d    = lfsr_q;
                    lfsr_d = lfsr_next;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            lfsr_q    <= SEED;
            misr_q    <= '0;
            cnt_q     <= '0;
            n_q       <= '0;
            prime_q   <= '0;
            x_q       <= '0;
            dut_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            misr_q    <= misr_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            prime_q   <= prime_d;
            x_q       <= x_d;
            dut_rst_q <= dut_rst_d;
        end
    end

    assign bus.x         = x_q;
    assign bus.dut_rst   = dut_rst_q;
    assign bus.busy      = (state_q == StPrime) || (state_q == StRun);
    assign bus.done      = (state_q == StDone);
    assign bus.signature = misr_q;
    assign bus.vec_count = cnt_q;
endmodule

// File: tb/tb_knot_stim_driver.sv
// Self-checking bench for knot_stim_driver: expected vectors are queued from a reference
// LFSR/MISR model and popped as the driver presents each vector.
module tb_knot_stim_driver;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned PRIME_CYC = 2;
    localparam logic [6:0]  SEED      = 7'h01;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    knot_stim_driver_if #(.CNT_W(CNT_W)) bus ();

    knot_stim_driver #(
        .SEED      (SEED),
        .CNT_W     (CNT_W),
        .PRIME_CYC (PRIME_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [6:0] m_lfsr;
    logic [8:0] y_const;
    int         y_mode;
    logic [6:0] exp_q[$];
    logic [15:0] sig_g1, sig_g2, sig_t, sig_tmp;

    // Stand-in controller: mode 0 constant, 1 golden, 2 golden with a rare-trigger payload.
    function automatic logic [8:0] ctrl_y(input logic [6:0] v, input int mode,
                                          input logic [8:0] k);
        logic [8:0] g;
        g = {v[0] ^ v[3], v[6:1] ^ v[5:0], v[2] & v[4], ~v[6]};
        if (mode == 0) return k;
        if (mode == 2 && v == 7'h55) return g ^ 9'h100;
        return g;
    endfunction

    function automatic logic [6:0] lfsr_step(input logic [6:0] l);
        return {l[5:0], l[6] ^ l[5]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [8:0] yv);
        return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {7'b0, yv};
    endfunction

    assign bus.y = ctrl_y(bus.x, y_mode, y_const);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_x", 32'(bus.x), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_dut_rst", 32'(bus.dut_rst), 32'h0);
        @(negedge clk);
        rst    = 1'b1;
        m_lfsr = SEED;
        exp_q.delete();
    endtask

    // Runs n vectors; optionally loads a seed with start, pulses start at vector
    // start_at, or drops rst at vector abort_at.
    task automatic do_run(input int n, input bit with_seed, input logic [6:0] seed,
                          input int start_at, input int abort_at,
                          output logic [15:0] sig);
        logic [15:0] m;
        logic [6:0]  v;
        m = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.nvec  = CNT_W'(n);
        if (with_seed) begin
            bus.seed_load = 1'b1;
            bus.seed_in   = seed;
            m_lfsr        = (seed == 7'h00) ? SEED : seed;
        end
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(m_lfsr);
            m      = misr_step(m, ctrl_y(m_lfsr, y_mode, y_const));
            m_lfsr = lfsr_step(m_lfsr);
        end
        @(posedge clk);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
        sig = bus.signature;
        if (n == 0) begin
            check("n0_done", 32'(bus.done), 32'h1);
            check("n0_dut_rst", 32'(bus.dut_rst), 32'h0);
            check("n0_sig", 32'(bus.signature), 32'h0);
            check("n0_cnt", 32'(bus.vec_count), 32'h0);
            return;
        end
        for (int p = 0; p < int'(PRIME_CYC); p++) begin
            check("prime_dut_rst", 32'(bus.dut_rst), 32'h1);
            check("prime_x", 32'(bus.x), 32'h0);
            check("prime_busy", 32'(bus.busy), 32'h1);
            @(negedge clk);
        end
        for (int i = 0; i < n; i++) begin
            v = exp_q.pop_front();
            check("vec_x", 32'(bus.x), 32'(v));
            if (i == 0) check("run_dut_rst", 32'(bus.dut_rst), 32'h0);
            if (i == abort_at) begin
                rst = 1'b0;
                #1;
                check("abort_x", 32'(bus.x), 32'h0);
                check("abort_busy", 32'(bus.busy), 32'h0);
                check("abort_done", 32'(bus.done), 32'h0);
                check("abort_cnt", 32'(bus.vec_count), 32'h0);
                check("abort_sig", 32'(bus.signature), 32'h0);
                @(negedge clk);
                rst    = 1'b1;
                m_lfsr = SEED;
                exp_q.delete();
                sig = '0;
                return;
            end
            if (i == start_at) bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("end_done", 32'(bus.done), 32'h1);
        check("end_busy", 32'(bus.busy), 32'h0);
        check("end_x", 32'(bus.x), 32'h0);
        check("end_cnt", 32'(bus.vec_count), 32'(n));
        check("end_sig", 32'(bus.signature), 32'(m));
        sig = bus.signature;
        @(negedge clk);
        check("hold_sig", 32'(bus.signature), 32'(m));
        check("hold_done", 32'(bus.done), 32'h1);
    endtask

    initial begin
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed_in   = '0;
        bus.nvec      = '0;
        y_mode        = 0;
        y_const       = '0;
        m_lfsr        = SEED;
        #1;
        check("reset_x", 32'(bus.x), 32'h0);
        check("reset_sig", 32'(bus.signature), 32'h0);
        check("reset_cnt", 32'(bus.vec_count), 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Seed 0x01, y tied low: 0x01,0x02,...,0x41,0x03 and signature 0.
        do_run(8, 1'b1, 7'h01, -1, -1, sig_tmp);
        check("seed_sig_zero", 32'(sig_tmp), 32'h0);
        // Start from DONE continues the LFSR; start during RUN is ignored.
        do_run(5, 1'b0, 7'h00, 2, -1, sig_tmp);

        // MISR arithmetic.
        y_const = 9'h001;
        do_run(2, 1'b0, 7'h00, -1, -1, sig_tmp);
        check("misr_y001", 32'(sig_tmp), 32'h0003);
        y_const = 9'h1FF;
        do_run(1, 1'b0, 7'h00, -1, -1, sig_tmp);
        check("misr_y1ff", 32'(sig_tmp), 32'h01FF);
        // N=0 from DONE clears the signature without a prime pulse.
        do_run(0, 1'b0, 7'h00, -1, -1, sig_tmp);

        // Zero seed falls back to SEED; seed with start in the same cycle is honoured.
        y_const = 9'h0A5;
        do_reset();
        do_run(3, 1'b1, 7'h00, -1, -1, sig_tmp);
        do_reset();
        do_run(4, 1'b1, 7'h55, -1, -1, sig_tmp);
        do_reset();
        do_run(0, 1'b0, 7'h00, -1, -1, sig_tmp);

        // Reset during the 4th vector, then a clean 3-vector run from SEED.
        do_run(8, 1'b0, 7'h00, -1, 3, sig_tmp);
        y_const = 9'h000;
        do_run(3, 1'b0, 7'h00, -1, -1, sig_tmp);

        // Controller hookup: golden twice, then the trojan variant.
        y_mode = 1;
        do_reset();
        do_run(200, 1'b1, 7'h2A, -1, -1, sig_g1);
        do_reset();
        do_run(200, 1'b1, 7'h2A, -1, -1, sig_g2);
        check("golden_repeat", 32'(sig_g2), 32'(sig_g1));
        y_mode = 2;
        do_reset();
        do_run(200, 1'b1, 7'h2A, -1, -1, sig_t);
        check("trojan_differs", 32'(sig_t != sig_g1), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
